// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU select decoder with an iterative HI/LO
// multiply/divide engine (one shift-add or restoring-subtract step per
// cycle), mfhi/mflo read-out and a pipeline stall interlock.
// Optional macro ALU_MULDIV_SIGNED_EN: when defined, mult/div are signed;
// when undefined they behave exactly like multu/divu.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [3:0]         aluOp_i,
    input  logic [5:0]         funct_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               stall_o,
    output logic               done_o,
    output logic               divZero_o,
    output logic [WIDTH-1:0]   hilo_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // rem_q: partial remainder / upper product half; quo_q: dividend-quotient / multiplier-lower half
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               div_q, div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic               dzo_q, dzo_d;

    logic               is_r;
    logic               is_md;
    logic               is_mfhi;
    logic               is_mflo;
    logic               accept;
    logic               op_signed;
    logic               op_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     shl;
    logic               sub_ok;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [3:0]         sel4;

    assign is_r    = (aluOp_i == 4'b0010);
    assign is_md   = is_r & (funct_i[5:2] == 4'b0110);
    assign is_mfhi = is_r & (funct_i == 6'b010000);
    assign is_mflo = is_r & (funct_i == 6'b010010);
    assign accept  = valid_i & is_md & ~done_q & (state_q == IDLE);
    assign op_div  = funct_i[1];

`ifdef ALU_MULDIV_SIGNED_EN
    assign op_signed = ~funct_i[0];
`else
    assign op_signed = 1'b0;
`endif

    assign a_neg = op_signed & a_i[WIDTH-1];
    assign b_neg = op_signed & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Restoring division: shift the next dividend bit into the remainder and compare
    assign shl    = {rem_q, quo_q[WIDTH-1]};
    assign sub_ok = (shl >= {1'b0, dvs_q});
    // Shift-add multiplication: add multiplicand when the current multiplier LSB is set
    assign sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    assign prod   = negq_q ? -{rem_q, quo_q} : {rem_q, quo_q};

    // ALU select decode from the operation class and the R-type funct field
    always_comb begin
        sel4 = 4'b0000;
        case (aluOp_i)
            4'b0000: sel4 = 4'b0010;
            4'b0001: sel4 = 4'b0110;
            4'b0011: sel4 = 4'b0010;
            4'b0100: sel4 = 4'b0000;
            4'b0101: sel4 = 4'b0001;
            4'b0110: sel4 = 4'b0111;
            4'b0111: sel4 = 4'b0011;
            4'b1000: sel4 = 4'b0100;
            4'b1001: sel4 = 4'b0101;
            4'b1011: sel4 = 4'b1001;
            4'b0010: begin
                case (funct_i)
                    6'b100000: sel4 = 4'b0010;
                    6'b100010: sel4 = 4'b0110;
                    6'b100100: sel4 = 4'b0000;
                    6'b100101: sel4 = 4'b0001;
                    6'b101010: sel4 = 4'b0111;
                    6'b100110: sel4 = 4'b0011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010010: sel4 = 4'b1010;
                    default: sel4 = 4'b0000;
                endcase
            end
            default: sel4 = 4'b0000;
        endcase
    end

    assign sel_o     = SEL_W'(sel4);
    assign stall_o   = valid_i & (is_md | is_mfhi | is_mflo) & ((state_q != IDLE) | accept) & ~done_q;
    assign hilo_o    = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    assign done_o    = done_q;
    assign divZero_o = dzo_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    // Next-state logic: accept, iterate WIDTH steps, then sign-fix and commit HI/LO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    div_d  = op_div;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    cnt_d  = '0;
                    dvs_d  = b_mag;
                    if (op_div && (b_i == '0)) begin
                        dz_d    = 1'b1;
                        rem_d   = a_i;
                        quo_d   = '1;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (div_q) begin
                    if (sub_ok) begin
                        rem_d = WIDTH'(shl - {1'b0, dvs_q});
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (dz_q) begin
                    hi_d  = rem_q;
                    lo_d  = quo_q;
                    dzo_d = 1'b1;
                end else if (div_q) begin
                    lo_d = negq_q ? -quo_q : quo_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset (reset aborts any operation)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Testbench for alu_muldiv_ctrl: ALU-select vector table, mul/div vector
// table checked through a scoreboard against a native-arithmetic model,
// and hand sequences for mflo interlock and reset abort.
module tb_alu_muldiv_ctrl;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [3:0]   aluOp;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         stall;
    logic         done;
    logic         divZero;
    logic [W-1:0] hilo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [3:0] op;
        logic [5:0] f;
        logic [3:0] sel;
    } sel_vec_t;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } md_vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];

    alu_muldiv_ctrl #(.WIDTH(W), .SEL_W(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .aluOp_i  (aluOp),
        .funct_i  (funct),
        .a_i      (a),
        .b_i      (b),
        .sel_o    (sel),
        .stall_o  (stall),
        .done_o   (done),
        .divZero_o(divZero),
        .hilo_o   (hilo),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic sg;
        logic signed [W-1:0] sx, sy;
        logic signed [2*W-1:0] px, py, p;
        logic [2*W-1:0] up;
`ifdef ALU_MULDIV_SIGNED_EN
        sg = ~f[0];
`else
        sg = 1'b0;
`endif
        e.dz  = 1'b0;
        e.lat = W + 2;
        if (f[1]) begin
            if (y == '0) begin
                e.hi  = x;
                e.lo  = '1;
                e.dz  = 1'b1;
                e.lat = 2;
            end else if (sg) begin
                sx = x;
                sy = y;
                e.lo = sx / sy;
                e.hi = sx % sy;
            end else begin
                e.lo = x / y;
                e.hi = x % y;
            end
        end else begin
            if (sg) begin
                px = {{W{x[W-1]}}, x};
                py = {{W{y[W-1]}}, y};
                p  = px * py;
                e.hi = p[2*W-1:W];
                e.lo = p[W-1:0];
            end else begin
                up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.hi = up[2*W-1:W];
                e.lo = up[W-1:0];
            end
        end
        return e;
    endfunction

    // Issue one mul/div in the cycle after the call, hold it while stalled, compare at done
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   c;
        bit   stall_ok;
        bit   seen;
        sb.push_back(model(f, x, y));
        @(posedge clk); #1;
        valid = 1'b1; aluOp = 4'b0010; funct = f; a = x; b = y;
        c = 0; stall_ok = 1'b1; seen = 1'b0;
        while (c < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        e = sb.pop_front();
        chk("stall_while_busy", 64'(stall_ok), 64'd1);
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("latency", 64'(c), 64'(e.lat));
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("divZero", 64'(divZero), 64'(e.dz));
            chk("stall_in_done", 64'(stall), 64'd0);
        end
    endtask

    sel_vec_t sv[22];
    md_vec_t  mv[10];

    initial begin
        exp_t e;
        int   c;
        bit   stall_ok;
        bit   seen;
        logic [W-1:0] ra, rb;

        sv[0]  = '{4'b0000, 6'b000000, 4'b0010};
        sv[1]  = '{4'b0001, 6'b000000, 4'b0110};
        sv[2]  = '{4'b0011, 6'b000000, 4'b0010};
        sv[3]  = '{4'b0100, 6'b000000, 4'b0000};
        sv[4]  = '{4'b0101, 6'b000000, 4'b0001};
        sv[5]  = '{4'b0110, 6'b000000, 4'b0111};
        sv[6]  = '{4'b0111, 6'b000000, 4'b0011};
        sv[7]  = '{4'b1000, 6'b000000, 4'b0100};
        sv[8]  = '{4'b1001, 6'b000000, 4'b0101};
        sv[9]  = '{4'b1011, 6'b100000, 4'b1001};
        sv[10] = '{4'b0010, 6'b100000, 4'b0010};
        sv[11] = '{4'b0010, 6'b100010, 4'b0110};
        sv[12] = '{4'b0010, 6'b100100, 4'b0000};
        sv[13] = '{4'b0010, 6'b100101, 4'b0001};
        sv[14] = '{4'b0010, 6'b101010, 4'b0111};
        sv[15] = '{4'b0010, 6'b100110, 4'b0011};
        sv[16] = '{4'b0010, F_MULT,    4'b1010};
        sv[17] = '{4'b0010, F_DIVU,    4'b1010};
        sv[18] = '{4'b0010, F_MFHI,    4'b1010};
        sv[19] = '{4'b0010, F_MFLO,    4'b1010};
        sv[20] = '{4'b0010, 6'b111111, 4'b0000};
        sv[21] = '{4'b1111, 6'b100000, 4'b0000};

        mv[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005};
        mv[1] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002};
        mv[2] = '{F_DIVU,  32'h00000007, 32'h00000002};
        mv[3] = '{F_DIV,   32'hFFFFFF00, 32'hFFFFFFF0};
        mv[4] = '{F_MULT,  32'h80000000, 32'h80000000};
        mv[5] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000};
        mv[6] = '{F_MULTU, 32'h00000000, 32'hDEADBEEF};
        mv[7] = '{F_DIVU,  32'h00000064, 32'h00000007};
        mv[8] = '{F_MULT,  32'h00001234, 32'hFFFFFFFF};
        mv[9] = '{F_DIV,   32'h00000064, 32'hFFFFFFF9};

        rst = 1'b1; valid = 1'b0; aluOp = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divZero", 64'(divZero), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        foreach (sv[i]) begin
            @(posedge clk); #1;
            aluOp = sv[i].op; funct = sv[i].f;
            #1;
            chk($sformatf("sel[%0d]", i), 64'(sel), 64'(sv[i].sel));
        end

        // multu with literal cross-check, then the held instruction must not be re-accepted
        run_op(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
        chk("multu_hi_lit", 64'(hi), 64'h1);
        chk("multu_lo_lit", 64'(lo), 64'hFFFFFFFE);
        @(posedge clk); #1;
        funct = F_MFHI;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("no_reaccept_stall", 64'(stall), 64'd0);
        chk("mfhi_read", 64'(hilo), 64'h1);

        // divide by zero, literal cross-check
        run_op(F_DIVU, 32'h00001234, 32'h00000000);
        chk("dz_hi_lit", 64'(hi), 64'h1234);
        chk("dz_lo_lit", 64'(lo), 64'hFFFFFFFF);

        // back-to-back table ops (each accepted in the cycle after the previous done)
        foreach (mv[i]) run_op(mv[i].f, mv[i].a, mv[i].b);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(6'b011000 | 6'($urandom_range(0, 3)), ra, rb);
        end

        // mflo issued 5 cycles into a mult, with valid dropped in between
        @(posedge clk); #1;
        valid = 1'b0;
        e = model(F_MULT, 32'h00000123, 32'hFFFFFF00);
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b1; aluOp = 4'b0010; funct = F_MULT; a = 32'h00000123; b = 32'hFFFFFF00;
        stall_ok = 1'b1; seen = 1'b0; c = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) valid = 1'b0;
            if (k == 5) begin valid = 1'b1; funct = F_MFLO; end
            @(negedge clk);
            c = k;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k >= 5 && !stall) stall_ok = 1'b0;
        end
        e = sb.pop_front();
        chk("mflo_stall_held", 64'(stall_ok), 64'd1);
        chk("mflo_done_seen", 64'(seen), 64'd1);
        chk("mflo_latency", 64'(c), 64'(e.lat));
        chk("mflo_hilo", 64'(hilo), 64'(e.lo));
        chk("mflo_sel", 64'(sel), 64'b1010);
        chk("mflo_stall_done", 64'(stall), 64'd0);
        chk("mflo_hi", 64'(hi), 64'(e.hi));

        // reset in cycle 10 of a div aborts it
        @(posedge clk); #1;
        valid = 1'b1; aluOp = 4'b0010; funct = F_DIVU; a = 32'd100; b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b1; funct = F_MFHI;
        @(negedge clk);
        chk("abort_idle_stall", 64'(stall), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_hilo", 64'(hilo), 64'd0);
        valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        @(posedge clk); #1;
        valid = 1'b1; aluOp = 4'b0010; funct = 6'b100000;
        @(negedge clk);
        chk("abort_add_sel", 64'(sel), 64'b0010);
        chk("abort_add_stall", 64'(stall), 64'd0);
        valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
